// File: rtl/ucpd_debounce_mc.sv
// ucpd_debounce_mc: multi-channel debounce/deglitch filter for slow UCPD inputs
// (VBUS-detect, FRS, attach pins). One shared microsecond prescaler and
// sample-tick generator drive NCH independent channels. Each channel has a
// 2-FF synchroniser, a candidate level and a stability counter with separate
// rise and fall confirm thresholds.
//
// Optional build macro: UCPD_DEBOUNCE_IRQ_EN
//   Defined   -> adds stat/stat_clr/irq (sticky per-channel edge status + IRQ).
//   Undefined -> those ports and registers are absent; the filter is unchanged.

// ---------------------------------------------------------------------------
// Per-channel filter: synchroniser, candidate register, stability counter.
// ---------------------------------------------------------------------------
module ucpd_debounce_ch #(
    parameter int   CNT_W   = 5,
    parameter logic RST_BIT = 1'b0
) (
    input  logic             ic_clk,
    input  logic             ic_rst_n,
    input  logic             en,
    input  logic             smp_tick,
    input  logic [CNT_W-1:0] det_rise,
    input  logic [CNT_W-1:0] det_fall,
    input  logic             din,
    output logic             dout,
    output logic             rise_p,
    output logic             fall_p
);

    logic             sync1_q, sync1_d;
    logic             sync_q,  sync_d;
    logic             cand_q,  cand_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             dout_q,  dout_d;
    logic             rise_q,  rise_d;
    logic             fall_q,  fall_d;

    logic [CNT_W-1:0] thr;
    logic [CNT_W:0]   cnt_inc;

    // Next-state for synchroniser, candidate, counter and committed level.
    always_comb begin
        sync1_d = din;
        sync_d  = sync1_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        // Threshold follows the direction we are trying to commit to.
        thr     = cand_q ? det_rise : det_fall;
        // One extra bit so the compare cannot wrap at the top of the range.
        cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

        if (!en) begin
            // Disabled: track the input but never commit; counting restarts.
            cand_d = sync_q;
            cnt_d  = '0;
        end else if (smp_tick) begin
            if (sync_q != cand_q) begin
                // Input moved since last sample: restart the stability window.
                cand_d = sync_q;
                cnt_d  = '0;
            end else if (cand_q != dout_q) begin
                // Stable candidate differs from output; thr of 0 or 1 both
                // commit on the first confirming tick.
                if (cnt_inc >= {1'b0, thr}) begin
                    dout_d = cand_q;
                    cnt_d  = '0;
                    rise_d = cand_q;
                    fall_d = ~cand_q;
                end else begin
                    cnt_d = cnt_inc[CNT_W-1:0];
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    // Channel state registers; synchroniser keeps running while disabled.
    always_ff @(posedge ic_clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            sync1_q <= RST_BIT;
            sync_q  <= RST_BIT;
            cand_q  <= RST_BIT;
            cnt_q   <= '0;
            dout_q  <= RST_BIT;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync_q  <= sync_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign dout   = dout_q;
    assign rise_p = rise_q;
    assign fall_p = fall_q;

endmodule

// ---------------------------------------------------------------------------
// Top: shared timebase plus NCH channel instances.
// ---------------------------------------------------------------------------
module ucpd_debounce_mc #(
    parameter int             NCH     = 4,
    parameter int             CNT_W   = 5,
    parameter logic [NCH-1:0] RST_VAL = {NCH{1'b0}}
) (
    input  logic             ic_clk,
    input  logic             ic_rst_n,
    input  logic             en,
    input  logic [5:0]       clk_freq,
    input  logic [9:0]       det_us,
    input  logic [CNT_W-1:0] det_rise,
    input  logic [CNT_W-1:0] det_fall,
    input  logic [NCH-1:0]   din,
    output logic [NCH-1:0]   dout,
    output logic [NCH-1:0]   rise_p,
    output logic [NCH-1:0]   fall_p,
    output logic             smp_tick
`ifdef UCPD_DEBOUNCE_IRQ_EN
    ,
    input  logic [NCH-1:0]   stat_clr,
    output logic [NCH-1:0]   stat,
    output logic             irq
`endif
);

    logic [5:0] us_cnt_q,   us_cnt_d;
    logic [9:0] smp_cnt_q,  smp_cnt_d;
    logic       smp_tick_q, smp_tick_d;

    logic [5:0] us_term;
    logic [9:0] smp_term;
    logic       us_tick;

    // Terminal counts; a zero setting behaves like one.
    always_comb begin
        us_term  = (clk_freq == 6'd0) ? 6'd0  : clk_freq - 6'd1;
        smp_term = (det_us == 10'd0)  ? 10'd0 : det_us - 10'd1;
        // Equality compare: a counter already past a newly lowered terminal
        // runs on to its natural width wrap before matching again.
        us_tick  = (us_cnt_q == us_term);
    end

    // Timebase next-state: microsecond prescaler feeding the sample divider.
    always_comb begin
        us_cnt_d   = us_cnt_q;
        smp_cnt_d  = smp_cnt_q;
        smp_tick_d = 1'b0;
        if (!en) begin
            us_cnt_d  = '0;
            smp_cnt_d = '0;
        end else begin
            us_cnt_d = us_tick ? 6'd0 : us_cnt_q + 6'd1;
            if (us_tick) begin
                if (smp_cnt_q == smp_term) begin
                    smp_cnt_d  = '0;
                    smp_tick_d = 1'b1;
                end else begin
                    smp_cnt_d = smp_cnt_q + 10'd1;
                end
            end
        end
    end

    // Timebase registers; smp_tick is registered so channels see a clean strobe.
    always_ff @(posedge ic_clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            us_cnt_q   <= '0;
            smp_cnt_q  <= '0;
            smp_tick_q <= 1'b0;
        end else begin
            us_cnt_q   <= us_cnt_d;
            smp_cnt_q  <= smp_cnt_d;
            smp_tick_q <= smp_tick_d;
        end
    end

    assign smp_tick = smp_tick_q;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        ucpd_debounce_ch #(
            .CNT_W   (CNT_W),
            .RST_BIT (RST_VAL[g])
        ) u_ch (
            .ic_clk   (ic_clk),
            .ic_rst_n (ic_rst_n),
            .en       (en),
            .smp_tick (smp_tick_q),
            .det_rise (det_rise),
            .det_fall (det_fall),
            .din      (din[g]),
            .dout     (dout[g]),
            .rise_p   (rise_p[g]),
            .fall_p   (fall_p[g])
        );
    end

`ifdef UCPD_DEBOUNCE_IRQ_EN
    logic [NCH-1:0] stat_q, stat_d;
    logic           irq_q,  irq_d;

    // Sticky edge status: a new edge wins over a clear in the same cycle.
    always_comb begin
        stat_d = (stat_q & ~stat_clr) | rise_p | fall_p;
        irq_d  = |stat_q;
    end

    // Status and interrupt registers.
    always_ff @(posedge ic_clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            stat_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            stat_q <= stat_d;
            irq_q  <= irq_d;
        end
    end

    assign stat = stat_q;
    assign irq  = irq_q;
`endif

endmodule

// File: tb/tb_ucpd_debounce_mc.sv
// Testbench for ucpd_debounce_mc. Expected edge events (cycle, pulses, level)
// are pushed when stimulus is applied; observed pulses are collected by a
// monitor and compared per scenario.
module tb_ucpd_debounce_mc;

    localparam int         NCH   = 4;
    localparam int         CNT_W = 5;
    localparam logic [3:0] RV    = 4'b0101;

    typedef struct packed {
        logic [31:0] cyc;
        logic [3:0]  rise;
        logic [3:0]  fall;
        logic [3:0]  dout;
    } ev_t;

    logic             ic_clk   = 1'b0;
    logic             ic_rst_n = 1'b0;
    logic             en       = 1'b0;
    logic [5:0]       clk_freq = 6'd4;
    logic [9:0]       det_us   = 10'd2;
    logic [CNT_W-1:0] det_rise = 5'd3;
    logic [CNT_W-1:0] det_fall = 5'd3;
    logic [NCH-1:0]   din      = RV;
    logic [NCH-1:0]   dout, rise_p, fall_p;
    logic             smp_tick;
`ifdef UCPD_DEBOUNCE_IRQ_EN
    logic [NCH-1:0]   stat_clr = '0;
    logic [NCH-1:0]   stat;
    logic             irq;
`endif

    ev_t sb[$];
    ev_t obs[$];
    int  nvec = 0;
    int  nerr = 0;
    int  cyc  = 0;

    ucpd_debounce_mc #(.NCH(NCH), .CNT_W(CNT_W), .RST_VAL(RV)) dut (
        .ic_clk   (ic_clk),
        .ic_rst_n (ic_rst_n),
        .en       (en),
        .clk_freq (clk_freq),
        .det_us   (det_us),
        .det_rise (det_rise),
        .det_fall (det_fall),
        .din      (din),
        .dout     (dout),
        .rise_p   (rise_p),
        .fall_p   (fall_p),
        .smp_tick (smp_tick)
`ifdef UCPD_DEBOUNCE_IRQ_EN
        ,
        .stat_clr (stat_clr),
        .stat     (stat),
        .irq      (irq)
`endif
    );

    always #5 ic_clk = ~ic_clk;
    always @(posedge ic_clk) cyc <= cyc + 1;

    // Record every observed pulse with its cycle and the level at that time.
    always @(negedge ic_clk)
        if ((rise_p | fall_p) != '0) obs.push_back({32'(cyc), rise_p, fall_p, dout});

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

    // Wait (bounded) for a visible sample strobe; returns its cycle.
    task automatic wait_tick(output int t);
        int n = 0;
        do begin
            @(negedge ic_clk);
            n++;
        end while (!smp_tick && n < 64);
        if (!smp_tick) begin
            nvec++;
            nerr++;
            $display("FAIL tick_timeout smp_tick=%b after %0d cycles, required 1", smp_tick, n);
        end
        t = cyc;
    endtask

    task automatic test_reset;
        int c1, bad;
        logic exp_tick;
        ev_t e;
        ic_rst_n = 1'b0; en = 1'b0; din = RV;
        repeat (3) @(negedge ic_clk);
        nvec++;
        if (dout !== RV || rise_p !== 4'b0 || fall_p !== 4'b0 || smp_tick !== 1'b0) begin
            nerr++;
            $display("FAIL reset_state dout=%b rise=%b fall=%b tick=%b, expected dout=%b pulses 0 tick 0",
                     dout, rise_p, fall_p, smp_tick, RV);
        end
        ic_rst_n = 1'b1; en = 1'b1;
        c1  = cyc + 1;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge ic_clk);
            if (i < 40) begin
                // clk_freq=4, det_us=2: strobe every 8th cycle, first one a full period in.
                exp_tick = ((cyc - c1 + 1) % 8 == 0);
                nvec++;
                if (smp_tick !== exp_tick) begin
                    nerr++;
                    $display("FAIL tick_period cyc=%0d smp_tick=%b, expected %b", cyc - c1, smp_tick, exp_tick);
                end
            end
            if ((rise_p | fall_p) != '0 || dout !== RV) bad++;
        end
        nvec++;
        if (bad != 0) begin
            nerr++;
            $display("FAIL idle %0d cycles with pulses or dout change, expected 0", bad);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
        end
        nvec++;
        if (obs.size() != 0) begin
            nerr++;
            $display("FAIL reset_release %0d pulses, expected 0", obs.size());
            obs.delete();
        end
    endtask

    task automatic test_clean_rise;
        int t;
        ev_t e, o;
        det_rise = 5'd3;
        wait_tick(t);
        din[1] = 1'b1;
        // 2 sync + load tick + 3 confirm ticks, visible after the committing edge.
        sb.push_back({32'(t + 33), 4'b0010, 4'b0000, 4'b0111});
        repeat (45) @(negedge ic_clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            nvec++;
            if (obs.size() == 0) begin
                nerr++;
                $display("FAIL clean_rise missing pulse, expected cyc=%0d rise=%b", e.cyc, e.rise);
            end else begin
                o = obs.pop_front();
                if (o !== e) begin
                    nerr++;
                    $display("FAIL clean_rise got cyc=%0d rise=%b fall=%b dout=%b, expected cyc=%0d rise=%b fall=%b dout=%b",
                             o.cyc, o.rise, o.fall, o.dout, e.cyc, e.rise, e.fall, e.dout);
                end
            end
        end
        nvec++;
        if (obs.size() != 0) begin
            nerr++;
            $display("FAIL clean_rise %0d extra pulses, expected 0", obs.size());
            obs.delete();
        end
    endtask

    task automatic test_glitch;
        int t;
        det_rise = 5'd3;
        wait_tick(t);
        din[3] = 1'b1;
        repeat (16) @(negedge ic_clk);
        din[3] = 1'b0;
        repeat (60) @(negedge ic_clk);
        nvec++;
        if (dout !== 4'b0111) begin
            nerr++;
            $display("FAIL glitch dout=%b, expected 0111", dout);
        end
        nvec++;
        if (obs.size() != 0) begin
            nerr++;
            $display("FAIL glitch %0d pulses, expected 0", obs.size());
            obs.delete();
        end
    endtask

    task automatic test_asym;
        int t;
        ev_t e, o;
        det_rise = 5'd1;
        det_fall = 5'd5;
        wait_tick(t);
        din[2] = 1'b0;
        // Load tick plus 5 confirm ticks.
        sb.push_back({32'(t + 49), 4'b0000, 4'b0100, 4'b0011});
        repeat (56) @(negedge ic_clk);
        wait_tick(t);
        din[2] = 1'b1;
        sb.push_back({32'(t + 17), 4'b0100, 4'b0000, 4'b0111});
        repeat (24) @(negedge ic_clk);
        // Threshold 0 behaves like 1.
        det_fall = 5'd0;
        wait_tick(t);
        din[2] = 1'b0;
        sb.push_back({32'(t + 17), 4'b0000, 4'b0100, 4'b0011});
        repeat (24) @(negedge ic_clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            nvec++;
            if (obs.size() == 0) begin
                nerr++;
                $display("FAIL asym missing pulse, expected cyc=%0d rise=%b fall=%b", e.cyc, e.rise, e.fall);
            end else begin
                o = obs.pop_front();
                if (o !== e) begin
                    nerr++;
                    $display("FAIL asym got cyc=%0d rise=%b fall=%b dout=%b, expected cyc=%0d rise=%b fall=%b dout=%b",
                             o.cyc, o.rise, o.fall, o.dout, e.cyc, e.rise, e.fall, e.dout);
                end
            end
        end
        nvec++;
        if (obs.size() != 0) begin
            nerr++;
            $display("FAIL asym %0d extra pulses, expected 0", obs.size());
            obs.delete();
        end
    endtask

    task automatic test_en_drop;
        int t, c1, bad;
        ev_t e, o;
        det_rise = 5'd1;
        wait_tick(t);
        din[3] = 1'b1;
        sb.push_back({32'(t + 17), 4'b1000, 4'b0000, 4'b1011});
        repeat (24) @(negedge ic_clk);
        det_fall = 5'd5;
        wait_tick(t);
        din[3] = 1'b0;
        // Drop enable after load and two confirm ticks.
        repeat (28) @(negedge ic_clk);
        en  = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ic_clk);
            if (smp_tick !== 1'b0 || (rise_p | fall_p) != '0) bad++;
        end
        nvec++;
        if (bad != 0 || dout !== 4'b1011) begin
            nerr++;
            $display("FAIL en_low dout=%b bad_cycles=%0d, expected dout=1011 bad_cycles=0", dout, bad);
        end
        en = 1'b1;
        c1 = cyc + 1;
        // Candidate was reloaded while disabled, so only the 5 confirm ticks remain;
        // tick j lands at edge c1+8j.
        sb.push_back({32'(c1 + 40), 4'b0000, 4'b1000, 4'b0011});
        repeat (50) @(negedge ic_clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            nvec++;
            if (obs.size() == 0) begin
                nerr++;
                $display("FAIL en_drop missing pulse, expected cyc=%0d rise=%b fall=%b", e.cyc, e.rise, e.fall);
            end else begin
                o = obs.pop_front();
                if (o !== e) begin
                    nerr++;
                    $display("FAIL en_drop got cyc=%0d rise=%b fall=%b dout=%b, expected cyc=%0d rise=%b fall=%b dout=%b",
                             o.cyc, o.rise, o.fall, o.dout, e.cyc, e.rise, e.fall, e.dout);
                end
            end
        end
        nvec++;
        if (obs.size() != 0) begin
            nerr++;
            $display("FAIL en_drop %0d extra pulses, expected 0", obs.size());
            obs.delete();
        end
    endtask

    task automatic test_multi;
        int t;
        ev_t e, o;
`ifdef UCPD_DEBOUNCE_IRQ_EN
        stat_clr = 4'hF;
        @(negedge ic_clk);
        stat_clr = 4'h0;
        repeat (2) @(negedge ic_clk);
        nvec++;
        if (stat !== 4'b0 || irq !== 1'b0) begin
            nerr++;
            $display("FAIL stat_preclear stat=%b irq=%b, expected 0000 0", stat, irq);
        end
`endif
        det_rise = 5'd2;
        det_fall = 5'd2;
        wait_tick(t);
        din[0] = 1'b0;
        din[3] = 1'b1;
        sb.push_back({32'(t + 25), 4'b1000, 4'b0001, 4'b1010});
`ifdef UCPD_DEBOUNCE_IRQ_EN
        repeat (26) @(negedge ic_clk);
        nvec++;
        if (stat !== 4'b1001) begin
            nerr++;
            $display("FAIL stat_set stat=%b, expected 1001", stat);
        end
        @(negedge ic_clk);
        nvec++;
        if (irq !== 1'b1) begin
            nerr++;
            $display("FAIL irq_set irq=%b, expected 1", irq);
        end
        stat_clr = 4'b1001;
        @(negedge ic_clk);
        stat_clr = 4'b0000;
        nvec++;
        if (stat !== 4'b0000) begin
            nerr++;
            $display("FAIL stat_clr stat=%b, expected 0000", stat);
        end
        @(negedge ic_clk);
        nvec++;
        if (irq !== 1'b0) begin
            nerr++;
            $display("FAIL irq_clr irq=%b, expected 0", irq);
        end
        repeat (4) @(negedge ic_clk);
`else
        repeat (32) @(negedge ic_clk);
`endif
        while (sb.size() > 0) begin
            e = sb.pop_front();
            nvec++;
            if (obs.size() == 0) begin
                nerr++;
                $display("FAIL multi missing pulse, expected cyc=%0d rise=%b fall=%b", e.cyc, e.rise, e.fall);
            end else begin
                o = obs.pop_front();
                if (o !== e) begin
                    nerr++;
                    $display("FAIL multi got cyc=%0d rise=%b fall=%b dout=%b, expected cyc=%0d rise=%b fall=%b dout=%b",
                             o.cyc, o.rise, o.fall, o.dout, e.cyc, e.rise, e.fall, e.dout);
                end
            end
        end
        nvec++;
        if (obs.size() != 0) begin
            nerr++;
            $display("FAIL multi %0d extra pulses, expected 0", obs.size());
            obs.delete();
        end
    endtask

    task automatic test_async_reset;
        det_fall = 5'd3;
        @(negedge ic_clk);
        din[1] = 1'b0;
        repeat (20) @(negedge ic_clk);
        #2 ic_rst_n = 1'b0;
        #1;
        nvec++;
        if (dout !== RV || rise_p !== 4'b0 || fall_p !== 4'b0 || smp_tick !== 1'b0) begin
            nerr++;
            $display("FAIL async_reset dout=%b rise=%b fall=%b tick=%b, expected dout=%b pulses 0 tick 0",
                     dout, rise_p, fall_p, smp_tick, RV);
        end
        din = RV;
        repeat (3) @(negedge ic_clk);
        ic_rst_n = 1'b1;
        repeat (200) @(negedge ic_clk);
        nvec++;
        if (dout !== RV) begin
            nerr++;
            $display("FAIL post_reset dout=%b, expected %b", dout, RV);
        end
        nvec++;
        if (obs.size() != 0) begin
            nerr++;
            $display("FAIL post_reset %0d pulses, expected 0", obs.size());
            obs.delete();
        end
    endtask

    initial begin
        test_reset;
        test_clean_rise;
        test_glitch;
        test_asym;
        test_en_drop;
        test_multi;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
